// File: rtl/conv_calc_sequencer.sv
// Sequences one convolution_calc instance through a layer pass: kernel load,
// padded raster walk with upstream pixel pull, adder drain, done pulse.
module conv_calc_sequencer #(
  parameter int unsigned RESOLUTIONS  = 5,
  parameter int unsigned XRES1        = 4,
  parameter int unsigned XRES2        = 12,
  parameter int unsigned XRES3        = 20,
  parameter int unsigned XRES4        = 28,
  parameter int unsigned XRES5        = 36,
  parameter int unsigned PAD          = 1,
  parameter int unsigned KX           = 3,
  parameter int unsigned KY           = 3,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned CW           = 8
) (
  input  logic             clock,
  input  logic             clock_sreset,
  input  logic             start,
  input  logic [2:0]       xres_sel,
  output logic             busy,
  output logic             done,
  output logic             cfg_error,
  input  logic             kin_valid,
  output logic             kin_ready,
  input  logic [WIDTH-1:0] kin_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [WIDTH-1:0] pix_data,
  output logic [2:0]       xres_select,
  output logic             kernel_valid,
  output logic [WIDTH-1:0] kernel_data,
  output logic             data_shift,
  output logic             enable_calc,
  output logic [WIDTH-1:0] data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KERNEL,
    S_FRAME,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [7:0] KLAST = 8'(KX * KY - 1);
  localparam logic [7:0] DLAST = 8'(DRAIN_CYCLES - 1);

  state_t           r_state;
  logic [CW-1:0]    r_x;
  logic [CW-1:0]    r_y;
  logic [7:0]       r_kcnt;
  logic [7:0]       r_dcnt;
  logic [2:0]       r_xres_select;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_error;
  logic             r_kernel_valid;
  logic [WIDTH-1:0] r_kernel_data;
  logic             r_data_shift;
  logic             r_enable_calc;
  logic [WIDTH-1:0] r_data;

  logic [CW-1:0]    w_p;
  logic [CW-1:0]    w_last;
  logic [CW-1:0]    w_hi;
  logic             w_interior;
  logic             w_sel_ok;
  logic             w_issue;

  function automatic logic [CW-1:0] f_padded(input logic [2:0] sel);
    case (sel)
      3'd0:    f_padded = CW'(XRES1 + 2 * PAD);
      3'd1:    f_padded = CW'(XRES2 + 2 * PAD);
      3'd2:    f_padded = CW'(XRES3 + 2 * PAD);
      3'd3:    f_padded = CW'(XRES4 + 2 * PAD);
      3'd4:    f_padded = CW'(XRES5 + 2 * PAD);
      default: f_padded = CW'(XRES1 + 2 * PAD);
    endcase
  endfunction

  always_comb begin
    w_p        = f_padded(r_xres_select);
    w_last     = w_p - CW'(1);
    w_hi       = w_p - CW'(PAD + 1);
    w_interior = (r_x >= CW'(PAD)) && (r_x <= w_hi) &&
                 (r_y >= CW'(PAD)) && (r_y <= w_hi);
    w_sel_ok   = {29'd0, xres_sel} < RESOLUTIONS;
    // Pad positions never wait on the upstream stream.
    w_issue    = (r_state == S_FRAME) && (!w_interior || pix_valid);
    kin_ready  = (r_state == S_KERNEL);
    pix_ready  = (r_state == S_FRAME) && w_interior;
  end

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      r_state        <= S_IDLE;
      r_x            <= '0;
      r_y            <= '0;
      r_kcnt         <= '0;
      r_dcnt         <= '0;
      r_xres_select  <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_cfg_error    <= 1'b0;
      r_kernel_valid <= 1'b0;
      r_kernel_data  <= '0;
      r_data_shift   <= 1'b0;
      r_enable_calc  <= 1'b0;
      r_data         <= '0;
    end else begin
      r_kernel_valid <= 1'b0;
      r_data_shift   <= 1'b0;
      r_enable_calc  <= 1'b0;
      r_done         <= 1'b0;
      r_cfg_error    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_sel_ok) begin
              r_xres_select <= xres_sel;
              r_x           <= '0;
              r_y           <= '0;
              r_kcnt        <= '0;
              r_dcnt        <= '0;
              r_busy        <= 1'b1;
              r_state       <= S_KERNEL;
            end else begin
              r_cfg_error <= 1'b1;
            end
          end
        end
        S_KERNEL: begin
          if (kin_valid) begin
            r_kernel_valid <= 1'b1;
            r_kernel_data  <= kin_data;
            r_kcnt         <= r_kcnt + 8'd1;
            if (r_kcnt == KLAST) r_state <= S_FRAME;
          end
        end
        S_FRAME: begin
          if (w_issue) begin
            r_data_shift  <= 1'b1;
            r_enable_calc <= w_interior;
            r_data        <= w_interior ? pix_data : '0;
            if (r_x == w_last) begin
              r_x <= '0;
              if (r_y == w_last) r_state <= S_DRAIN;
              else               r_y     <= r_y + CW'(1);
            end else begin
              r_x <= r_x + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DLAST) r_state <= S_DONE;
          else                 r_dcnt  <= r_dcnt + 8'd1;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign cfg_error    = r_cfg_error;
  assign xres_select  = r_xres_select;
  assign kernel_valid = r_kernel_valid;
  assign kernel_data  = r_kernel_data;
  assign data_shift   = r_data_shift;
  assign enable_calc  = r_enable_calc;
  assign data         = r_data;

endmodule

// File: tb/tb_conv_calc_sequencer.sv
// Scoreboard bench for conv_calc_sequencer: a pass-level model predicts the
// kernel word order, the padded shift stream and the done cycle.
module tb_conv_calc_sequencer;

  localparam int W = 16;

  logic         clock;
  logic         clock_sreset;
  logic         start;
  logic [2:0]   xres_sel;
  logic         busy, done, cfg_error;
  logic         kin_valid, kin_ready;
  logic [W-1:0] kin_data;
  logic         pix_valid, pix_ready;
  logic [W-1:0] pix_data;
  logic [2:0]   xres_select;
  logic         kernel_valid;
  logic [W-1:0] kernel_data;
  logic         data_shift, enable_calc;
  logic [W-1:0] data;

  conv_calc_sequencer dut (
    .clock(clock), .clock_sreset(clock_sreset), .start(start), .xres_sel(xres_sel),
    .busy(busy), .done(done), .cfg_error(cfg_error),
    .kin_valid(kin_valid), .kin_ready(kin_ready), .kin_data(kin_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .xres_select(xres_select), .kernel_valid(kernel_valid), .kernel_data(kernel_data),
    .data_shift(data_shift), .enable_calc(enable_calc), .data(data)
  );

  typedef struct {logic en; logic [W-1:0] d;} shift_t;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [W-1:0] kw[9];
  int           ks[9];
  logic [W-1:0] pw[$];
  int           ps[$];
  logic [W-1:0] kexp[$];
  shift_t       sexp[$];
  int           dexp[$];

  int drv_start = -1;
  bit drv_on = 0;
  int kidx, kwait, pidx, pwait, npix;
  bit kbeat, pbeat;
  int kbeats, pbeats;
  bit early_pix, pass_done;
  int cur_sel;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int xres_of(input int s);
    case (s)
      0: return 4;
      1: return 12;
      2: return 20;
      3: return 28;
      default: return 36;
    endcase
  endfunction

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Handshake capture: values are stable in the second half of the cycle.
  initial forever begin
    @(negedge clock);
    kbeat = kin_valid && kin_ready;
    pbeat = pix_valid && pix_ready;
    if (drv_on) begin
      if (kbeat) kbeats++;
      if (pbeat) pbeats++;
    end
  end

  // Source drivers: after each accepted word, idle for its stall count.
  initial forever begin
    @(posedge clock);
    #1;
    if (cyc == drv_start) begin
      drv_on = 1;
      kidx = 0; kwait = ks[0];
      pidx = 0; pwait = ps[0];
    end else if (drv_on) begin
      if (kbeat) begin
        kidx++;
        if (kidx < 9) kwait = ks[kidx];
      end else if (kwait > 0) kwait--;
      if (pbeat) begin
        pidx++;
        if (pidx < npix) pwait = ps[pidx];
      end else if (pwait > 0) pwait--;
    end
    kin_valid = drv_on && (kidx < 9) && (kwait == 0);
    if (drv_on && kidx < 9) kin_data = kw[kidx];
    pix_valid = drv_on && (pidx < npix) && (pwait == 0);
    if (drv_on && pidx < npix) pix_data = pw[pidx];
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clock);
    if (!clock_sreset) begin
      if (kernel_valid) begin
        if (kexp.size() == 0) chk("kernel_extra", 1, 0);
        else chk("kernel_data", kernel_data, kexp.pop_front());
      end
      if (pix_ready && kexp.size() != 0) early_pix = 1;
      if (data_shift) begin
        if (sexp.size() == 0) chk("shift_extra", 1, 0);
        else begin
          shift_t e;
          e = sexp.pop_front();
          chk("enable_calc", enable_calc, e.en);
          chk("data", data, e.d);
        end
      end else if (enable_calc) chk("enable_without_shift", 1, 0);
      if (done) begin
        if (dexp.size() == 0) chk("done_extra", 1, 0);
        else chk("done_cycle", cyc, dexp.pop_front());
        chk("kernel_left", kexp.size(), 0);
        chk("shift_left", sexp.size(), 0);
        chk("kernel_beats", kbeats, 9);
        chk("pix_beats", pbeats, npix);
        chk("early_pix_ready", early_pix, 0);
        chk("busy_at_done", busy, 0);
        chk("xres_select", xres_select, cur_sel);
        pass_done = 1;
      end
    end
  end

  // mode: 0 no stalls, 1 kin toggling, 2 five-cycle pixel stall at (3,3), 3 random
  task automatic run_pass(input int sel, input int mode, input int restart_at, input int abort_at);
    int xr, p, t, prev, pprev, e, avail, k, rel, e0, n;
    cur_sel = sel;
    xr = xres_of(sel);
    p = xr + 2;
    npix = xr * xr;
    pw.delete(); ps.delete();
    for (int i = 0; i < 9; i++) begin
      kw[i] = W'($urandom);
      ks[i] = 0;
      if (mode == 1 && i > 0) ks[i] = 1;
      if (mode == 3 && $urandom_range(0, 3) == 0) ks[i] = $urandom_range(1, 3);
    end
    for (int i = 0; i < npix; i++) begin
      pw.push_back(W'($urandom_range(1, 65535)));
      ps.push_back((mode == 3 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
    end
    if (mode == 2) ps[2 * xr + 2] = 5;
    // Reference: earliest edge for each handshake, relative to the start edge.
    t = 1; prev = 0;
    for (int i = 0; i < 9; i++) begin
      kexp.push_back(kw[i]);
      avail = prev + 1 + ks[i];
      e = (t > avail) ? t : avail;
      prev = e; t = e + 1;
    end
    pprev = 0; k = 0;
    for (int y = 0; y < p; y++)
      for (int x = 0; x < p; x++) begin
        if (x >= 1 && x <= p - 2 && y >= 1 && y <= p - 2) begin
          avail = pprev + 1 + ps[k];
          e = (t > avail) ? t : avail;
          pprev = e;
          sexp.push_back('{1'b1, pw[k]});
          k++;
        end else begin
          e = t;
          sexp.push_back('{1'b0, W'(0)});
        end
        t = e + 1;
      end
    rel = (t - 1) + 9;

    @(negedge clock);
    e0 = cyc + 1;
    dexp.push_back(e0 + rel);
    kbeats = 0; pbeats = 0; early_pix = 0; pass_done = 0;
    drv_start = e0;
    start = 1; xres_sel = 3'(sel);
    @(negedge clock);
    start = 0; xres_sel = 3'($urandom_range(0, 7));
    chk("kin_ready_after_start", kin_ready, 1);
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!pass_done && n < 8000) begin
      if (restart_at != 0 && n == restart_at) begin
        start = 1; xres_sel = 3'd4;
      end
      if (abort_at != 0 && n == abort_at) begin
        #2 clock_sreset = 1;
        #1;
        chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
        chk("rst_cfg_error", cfg_error, 0); chk("rst_kernel_valid", kernel_valid, 0);
        chk("rst_kernel_data", kernel_data, 0); chk("rst_data_shift", data_shift, 0);
        chk("rst_enable_calc", enable_calc, 0); chk("rst_data", data, 0);
        chk("rst_xres_select", xres_select, 0); chk("rst_kin_ready", kin_ready, 0);
        chk("rst_pix_ready", pix_ready, 0);
        drv_on = 0; drv_start = -1; kin_valid = 0; pix_valid = 0;
        kexp.delete(); sexp.delete(); dexp.delete();
        @(negedge clock);
        @(negedge clock);
        clock_sreset = 0;
        @(negedge clock);
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_idle_kin_ready", kin_ready, 0);
        return;
      end
      @(negedge clock);
      n++;
      start = 0;
      if (restart_at != 0 && n == restart_at + 1) chk("restart_no_cfg_error", cfg_error, 0);
    end
    if (!pass_done) chk("pass_timeout", 0, 1);
    drv_on = 0; drv_start = -1;
    repeat (3) @(negedge clock);
  endtask

  task automatic bad_start(input int sel);
    @(negedge clock);
    start = 1; xres_sel = 3'(sel);
    @(negedge clock);
    start = 0;
    chk("cfg_error_pulse", cfg_error, 1);
    chk("cfg_busy", busy, 0);
    chk("cfg_kin_ready", kin_ready, 0);
    @(negedge clock);
    chk("cfg_error_one_cycle", cfg_error, 0);
    chk("cfg_still_idle", kin_ready, 0);
  endtask

  initial begin
    clock_sreset = 1; start = 0; xres_sel = 0;
    kin_valid = 0; pix_valid = 0; kin_data = 0; pix_data = 0;
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_data_shift", data_shift, 0);
    chk("reset_kernel_valid", kernel_valid, 0);
    chk("reset_xres_select", xres_select, 0);
    clock_sreset = 0;
    @(negedge clock);

    run_pass(0, 0, 0, 0);     // basic pass, done at +54 edges
    run_pass(2, 2, 0, 0);     // pixel stall
    run_pass(0, 1, 0, 0);     // kin toggling
    bad_start(5);
    bad_start(7);
    run_pass(0, 0, 20, 0);    // start ignored mid-frame
    run_pass(1, 0, 0, 40);    // async reset mid-frame
    run_pass(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_pass($urandom_range(0, 4), 3, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_calc_sequencer.md
Name: conv_calc_sequencer

Overview:
Controller that sequences one convolution_calc instance through a full layer pass. On start it loads KX*KY kernel weights, then raster-walks the zero-padded input frame at the selected resolution. It inserts pad zeros itself and pulls interior pixels from an upstream valid/ready stream. It then drains the adder pipeline and pulses done. It sits between the feature-map fetch logic and convolution_calc, and drives all of convolution_calc's control and data inputs.

Parameters:
RESOLUTIONS, 5, number of selectable frame resolutions
XRES1..XRES5, 4/12/20/28/36, unpadded square frame edge for select 0..4
PAD, 1, zero border width on each side
KX, 3, kernel width
KY, 3, kernel height
WIDTH, 16, data word width (1+EXP+MANT)
DRAIN_CYCLES, 8, cycles held in DRAIN after the last shift
CW, 8, width of internal x/y counters; must hold XRES5+2*PAD

Ports:
clock  in  1  system clock
clock_sreset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pass request
xres_sel  in  3  resolution index latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of pass
cfg_error  out  1  one-cycle pulse when start is rejected for bad xres_sel
kin_valid  in  1  kernel word available
kin_ready  out  1  sequencer accepts kernel word
kin_data  in  WIDTH  kernel word
pix_valid  in  1  interior pixel available
pix_ready  out  1  sequencer accepts pixel
pix_data  in  WIDTH  pixel word
xres_select  out  3  to convolution_calc, latched xres_sel
kernel_valid  out  1  to convolution_calc
kernel_data  out  WIDTH  to convolution_calc
data_shift  out  1  to convolution_calc
enable_calc  out  1  to convolution_calc
data  out  WIDTH  to convolution_calc

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, cfg_error, kernel_valid, data_shift, enable_calc = 0; data, kernel_data, xres_select, counters = 0.
- All outputs are registered except kin_ready and pix_ready, which are combinational from state and counters.
- P = XRES[xres_select] + 2*PAD is the padded edge.
- IDLE:
  - start with xres_sel < RESOLUTIONS: latch xres_select, clear counters, busy<=1, go to KERNEL.
  - start with xres_sel >= RESOLUTIONS: cfg_error pulses 1 cycle, stay in IDLE.
- KERNEL:
  - kin_ready=1.
  - Each kin_valid&&kin_ready beat: next cycle kernel_valid=1, kernel_data=kin_data, kcount++.
  - Non-beat cycles: kernel_valid=0.
  - After the KX*KY-th beat, go to FRAME. kin_ready is 0 from the cycle after that beat.
- FRAME:
  - Position (x,y) walks x=0..P-1 inner, y=0..P-1 outer.
  - Interior means PAD<=x<=P-PAD-1 and PAD<=y<=P-PAD-1.
  - Pad position: issued unconditionally. Next cycle: data_shift=1, enable_calc=0, data=0.
  - Interior position: pix_ready=1. Issued only on pix_valid. Next cycle: data_shift=1, enable_calc=1, data=pix_data.
  - Interior, pix_valid=0: stall. Next cycle data_shift=0, enable_calc=0, data holds, counters hold.
  - pix_ready=0 at pad positions and in every other state.
  - Counter advance on issue: x wraps P-1 -> 0 and increments y. Issuing (P-1,P-1) goes to DRAIN.
  - Exactly P*P shifts and XRES^2 pixel beats occur per pass.
- DRAIN:
  - data_shift=0, enable_calc=0.
  - Hold DRAIN_CYCLES cycles, then go to DONE.
- DONE: done=1 for one cycle, busy<=0, go to IDLE.
- Latency:
  - start to first kin_ready: 1 cycle.
  - With zero backpressure, start to done = 1 + KX*KY + P*P + DRAIN_CYCLES + 1 cycles.
- start while busy is ignored (no cfg_error).
- kin_valid outside KERNEL and pix_valid outside interior FRAME positions are ignored.
- xres_sel changes while busy have no effect.

Test Plan:
1. Reset, then start with xres_sel=0 and continuous kin/pix valid.
   -> 9 kernel_valid pulses carrying kin_data in order.
   -> 36 data_shift pulses; enable_calc on exactly 16 of them (x,y in 1..4); data=0 on the other 20.
   -> done 1+9+36+8+1=55 cycles after start.
2. xres_sel=2, pix_valid deasserted for 5 cycles at interior (3,3).
   -> data_shift=0 for those 5 cycles; counters hold; 484 total shifts; 400 pixel beats; done delayed by 5.
3. kin_valid toggling 1/0 each cycle.
   -> kernel_valid only on beat+1 cycles; FRAME entered after the 9th beat; no pix_ready before then.
4. start with xres_sel=5 and with xres_sel=7.
   -> cfg_error 1-cycle pulse each; busy stays 0; no kin_ready.
5. start re-asserted mid-FRAME with xres_sel=4.
   -> ignored; xres_select unchanged; pass completes at the original resolution.
6. clock_sreset asserted mid-cycle during FRAME, xres_sel=1.
   -> all outputs 0 immediately (before the next edge); after release, IDLE; a new start completes a normal pass.
